// File: rtl/spectrum_bar_buffer.sv
// Purpose: frame-synchronous double buffer between the spectrum analyser stream and the
//          VGA pixel path. A frame of bin magnitudes fills wbuf; each VSync falling edge
//          commits wbuf into dbuf (or ages dbuf when no new frame arrived).
// Latency: rd_height is registered, 1 cycle after rd_idx; a commit pass takes NUM_BINS
//          cycles after the edge-detect cycle, then frame_done pulses for one cycle.
// Backpressure: bin_ready is a registered state decode (high only in FILL); once a
//          frame is complete it drops until the commit pass finishes.
//
// Ports:
//   clk, rst           pixel clock, asynchronous active-high reset
//   bin_data/_valid/_last/bin_ready   magnitude input stream (valid/ready)
//   vsync              active-low VSync from the sync generator
//   rd_idx/rd_height   column read port (height is 0 for rd_idx >= NUM_BINS)
//   frame_done         one-cycle pulse at the end of each commit/decay pass
//
// Build option: define PEAK_HOLD_EN for peak-hold with per-frame decay of DECAY;
// without it, commits are direct copies and bars hold between frames.

module spectrum_bar_buffer #(
  parameter int NUM_BINS = 16,
  parameter int MAG_W    = 8,
  parameter int IDX_W    = 4,
  parameter int DECAY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] bin_data,
  input  logic             bin_valid,
  input  logic             bin_last,
  output logic             bin_ready,
  input  logic             vsync,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [MAG_W-1:0] rd_height,
  output logic             frame_done
);

  // Array address width; IDX_W may be wider than needed (e.g. 8 bins on a 4-bit index).
  localparam int               AW         = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BINS - 1);
  localparam logic [IDX_W:0]   NUM_BINS_W = (IDX_W+1)'(NUM_BINS);
  localparam logic [MAG_W-1:0] DECAY_W    = MAG_W'(DECAY);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PENDING = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wptr_q, wptr_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             have_new_q, have_new_d;
  logic             vsync_dly_q, vsync_dly_d;   // one-cycle delayed vsync
  logic             bin_ready_q, bin_ready_d;
  logic             frame_done_q, frame_done_d;
  logic [MAG_W-1:0] rd_height_q, rd_height_d;
  logic [MAG_W-1:0] wbuf_q [NUM_BINS];
  logic [MAG_W-1:0] wbuf_d [NUM_BINS];
  logic [MAG_W-1:0] dbuf_q [NUM_BINS];
  logic [MAG_W-1:0] dbuf_d [NUM_BINS];

  logic accept;
  logic vs_fall;

  // Saturating per-frame decrement.
  function automatic logic [MAG_W-1:0] dec(input logic [MAG_W-1:0] x);
    return (x > DECAY_W) ? (x - DECAY_W) : '0;
  endfunction

  // Commit of a fresh bin against the currently displayed height.
  function automatic logic [MAG_W-1:0] commit_new(input logic [MAG_W-1:0] new_v,
                                                  input logic [MAG_W-1:0] old_v);
`ifdef PEAK_HOLD_EN
    logic [MAG_W-1:0] aged;
    aged = dec(old_v);
    return (new_v > aged) ? new_v : aged;
`else
    return (old_v == old_v) ? new_v : new_v;
`endif
  endfunction

  // Ageing of a displayed height when no new frame arrived before the edge.
  function automatic logic [MAG_W-1:0] commit_old(input logic [MAG_W-1:0] old_v);
`ifdef PEAK_HOLD_EN
    return dec(old_v);
`else
    return old_v;
`endif
  endfunction

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    have_new_d   = have_new_q;
    wbuf_d       = wbuf_q;
    dbuf_d       = dbuf_q;
    frame_done_d = 1'b0;
    vsync_dly_d  = vsync;

    accept  = bin_valid & bin_ready_q;
    // Falling edge is seen in the first cycle vsync is sampled low.
    vs_fall = vsync_dly_q & ~vsync;

    case (state_q)
      FILL: begin
        if (vs_fall) begin
          // Edge before the frame completed: abandon the partial frame and just age dbuf.
          // A bin handshaked in this same cycle belongs to the abandoned frame.
          state_d    = UPDATE;
          cnt_d      = '0;
          have_new_d = 1'b0;
          wptr_d     = '0;
        end else if (accept) begin
          wbuf_d[wptr_q[AW-1:0]] = bin_data;
          if (bin_last || (wptr_q == LAST_IDX)) begin
            state_d = PENDING;
            wptr_d  = '0;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end

      PENDING: begin
        if (vs_fall) begin
          state_d    = UPDATE;
          cnt_d      = '0;
          have_new_d = 1'b1;
        end
      end

      UPDATE: begin
        // One bin per cycle; further vsync edges are ignored until the pass completes.
        if (have_new_q) begin
          dbuf_d[cnt_q[AW-1:0]] = commit_new(wbuf_q[cnt_q[AW-1:0]], dbuf_q[cnt_q[AW-1:0]]);
        end else begin
          dbuf_d[cnt_q[AW-1:0]] = commit_old(dbuf_q[cnt_q[AW-1:0]]);
        end
        if (cnt_q == LAST_IDX) begin
          state_d      = FILL;
          cnt_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = FILL;
        wptr_d  = '0;
        cnt_d   = '0;
      end
    endcase

    // Registered decode of the next state keeps bin_ready free of any path from bin_valid.
    bin_ready_d = (state_d == FILL);

    // Index wider than the table reads as zero instead of aliasing onto a real bar.
    if ({1'b0, rd_idx} < NUM_BINS_W) begin
      rd_height_d = dbuf_q[rd_idx[AW-1:0]];
    end else begin
      rd_height_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wptr_q       <= '0;
      cnt_q        <= '0;
      have_new_q   <= 1'b0;
      vsync_dly_q  <= 1'b1;
      bin_ready_q  <= 1'b1;
      frame_done_q <= 1'b0;
      rd_height_q  <= '0;
      for (int i = 0; i < NUM_BINS; i++) begin
        wbuf_q[i] <= '0;
        dbuf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      have_new_q   <= have_new_d;
      vsync_dly_q  <= vsync_dly_d;
      bin_ready_q  <= bin_ready_d;
      frame_done_q <= frame_done_d;
      rd_height_q  <= rd_height_d;
      wbuf_q       <= wbuf_d;
      dbuf_q       <= dbuf_d;
    end
  end

  assign bin_ready  = bin_ready_q;
  assign frame_done = frame_done_q;
  assign rd_height  = rd_height_q;

endmodule

// File: doc/spectrum_bar_buffer.md
# spectrum_bar_buffer

Frame-synchronous double buffer between the spectrum analyser and the VGA pixel path. It accepts one frame of bin magnitudes over a valid/ready stream into a write buffer. On the start of each VSync pulse it commits that frame into a display buffer, with optional peak-hold/decay. The pixel generator reads the display buffer per column, and that read is never torn mid-frame.

## Interface
Parameters:
- NUM_BINS, 16, number of spectrum bars; power of two, 2..64
- MAG_W, 8, magnitude and bar-height width
- IDX_W, 4, log2(NUM_BINS)
- DECAY, 2, per-frame decrement applied when PEAK_HOLD_EN is defined

Ports:
- clk  in  1  pixel clock, same clock as the VGA sync/pixel path
- rst  in  1  asynchronous, active-high reset
- bin_data  in  MAG_W  magnitude of the current bin
- bin_valid  in  1  bin_data is valid
- bin_last  in  1  qualifies the final bin of a frame
- bin_ready  out  1  block accepts a bin this cycle
- vsync  in  1  VSync from the VGA sync generator, active-low
- rd_idx  in  IDX_W  column (bar) index requested by the pixel generator
- rd_height  out  MAG_W  display-buffer height for rd_idx, registered
- frame_done  out  1  one-cycle pulse when a commit/decay pass ends

## Operation
- Storage:
  - wbuf[NUM_BINS] is the write buffer; dbuf[NUM_BINS] is the display buffer.
  - wptr is IDX_W bits; cnt is the update counter.
  - vsync_d is a one-cycle delayed copy of vsync.
- FSM states: FILL, PENDING, UPDATE.
- FILL:
  - bin_ready=1.
  - A bin is accepted when bin_valid&bin_ready: wbuf[wptr]<=bin_data and wptr increments.
  - When the accepted bin has bin_last=1 or wptr==NUM_BINS-1, go to PENDING and reset wptr to 0.
- PENDING: bin_ready=0; wait for a vsync edge.
- A vsync edge is vsync_d==1 && vsync==0.
  - Edge in FILL or PENDING: go to UPDATE with cnt=0 and latch have_new = (state==PENDING).
  - Edge in UPDATE: ignored.
- UPDATE:
  - One bin per cycle, cnt from 0 to NUM_BINS-1.
  - have_new=1: dbuf[cnt] <= f(wbuf[cnt], dbuf[cnt]).
  - have_new=0: dbuf[cnt] <= g(dbuf[cnt]).
  - After cnt==NUM_BINS-1: pulse frame_done and go to FILL.
  - An edge arriving while in FILL discards the partial frame: wptr resets to 0. Partially written wbuf entries are overwritten next frame.
- Early bin_last, fewer than NUM_BINS bins: the unwritten wbuf entries keep their values from the previous frame and are committed as-is.
- A bin_valid while bin_ready=0 is not consumed; the source must hold it.
- Read: rd_height <= (rd_idx < NUM_BINS) ? dbuf[rd_idx] : 0.
- Arithmetic:
  - Decrement saturates at 0: dec(x) = (x > DECAY) ? x-DECAY : 0.
  - No overflow is possible because values are never summed.
- Reset:
  - Clears wbuf, dbuf, wptr, cnt and have_new; sets vsync_d=1; state goes to FILL.
  - Outputs after reset: bin_ready=1, rd_height=0, frame_done=0.
  - Reset asserted mid-UPDATE or mid-FILL drops all data.

## Timing
- Read latency is 1 cycle: rd_idx sampled at edge N gives rd_height valid after edge N.
- Edge detection:
  - The vsync falling edge is detected in the cycle vsync is first sampled low.
  - UPDATE starts on the next edge and lasts exactly NUM_BINS cycles.
  - frame_done is high in the cycle after the final dbuf write.
  - bin_ready returns to 1 in the same cycle as frame_done.
- While in UPDATE, reads can return a mix of old and new dbuf entries. UPDATE is far shorter than the VSync pulse, so no visible pixel is affected.
- bin_ready is a registered state decode, with no combinational path from bin_valid.
- Accepting the last bin drops bin_ready on the following cycle. At most one bin is accepted per cycle.

## Configuration
- PEAK_HOLD_EN:
  - Defined:
    - f(new, old) = max(new, dec(old)).
    - g(old) = dec(old): bars decay by DECAY each frame without new data.
  - Undefined:
    - f(new, old) = new, a direct copy.
    - g(old) = old: bars hold.
    - DECAY is unused.

## Test plan
- Reset mid-UPDATE (cnt=5) -> all rd_height=0, bin_ready=1, state FILL, and no frame_done pulse.
- Stream 16 bins of value 10*i, the last with bin_last, then drop vsync -> bin_ready=0 after the last bin. UPDATE takes 16 cycles, then frame_done pulses. rd_idx=3 reads 30 one cycle later.
- PEAK_HOLD_EN, DECAY=2, dbuf[0]=50, then a new frame with bin0=20 -> 48. A further edge with no new frame -> 46. Starting from 1 -> 0 (saturation).
- No macro, same sequence -> 20, then held at 20 on the no-data edge.
- Frame with bin_last after 4 bins -> bins 4..15 keep their prior values. A vsync edge mid-fill (after 7 bins, no bin_last) -> no commit, and wptr restarts at 0.
- bin_valid held high in PENDING for 20 cycles -> nothing consumed and wbuf unchanged. rd_idx beyond NUM_BINS (with NUM_BINS=8, IDX_W=4, rd_idx=12) -> rd_height=0.
